// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, buffers the returned word for decode
// behind a valid/ready handshake, and handles redirects and halt.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ADDR_BITS = 10
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc,
    input  logic [31:0] inst_in,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        halted,
    output logic        misalign_err
);

    typedef enum logic [1:0] {FETCH, HOLD, HALTED} state_t;

    // Word-aligned and confined to the memory's byte-address range.
    localparam logic [31:0] PC_MASK = 32'((64'd1 << ADDR_BITS) - 64'd1) & ~32'd3;

    state_t      state, state_n;
    logic [31:0] pc_n, if_inst_n, if_pc_n;
    logic        if_valid_n, misalign_n;
    logic        accept, slot_free;

    assign accept    = if_valid & if_ready;
    assign slot_free = !if_valid | if_ready;
    assign halted    = (state == HALTED);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
        state_n    = state;
        pc_n       = pc;
        if_valid_n = if_valid;
        if_inst_n  = if_inst;
        if_pc_n    = if_pc;
        misalign_n = 1'b0;
        case (state)
            FETCH, HOLD: begin
                if (redirect_valid) begin
                    pc_n       = redirect_pc & PC_MASK;
                    if_valid_n = 1'b0;
                    misalign_n = |redirect_pc[1:0];
                    state_n    = FETCH;
                end else if (halt_req) begin
                    if (accept) if_valid_n = 1'b0;
                    state_n = HALTED;
                end else if (slot_free) begin
                    if_inst_n  = inst_in;
                    if_pc_n    = pc;
                    if_valid_n = 1'b1;
                    pc_n       = (pc + 32'd4) & PC_MASK;
                    state_n    = FETCH;
                end else begin
                    state_n = HOLD;
                end
            end
            HALTED: begin
                // Only reset leaves HALTED; just drain the buffer once taken.
                if (accept) if_valid_n = 1'b0;
            end
            default: state_n = FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= FETCH;
            pc           <= RESET_PC & PC_MASK;
            if_valid     <= 1'b0;
            if_inst      <= 32'd0;
            if_pc        <= 32'd0;
            misalign_err <= 1'b0;
        end else begin
            state        <= state_n;
            pc           <= pc_n;
            if_valid     <= if_valid_n;
            if_inst      <= if_inst_n;
            if_pc        <= if_pc_n;
            misalign_err <= misalign_n;
        end
    end

endmodule
